ecp5_pll_phase_ctrl: RTL and testbench

// - Sequencer for the ECP5 PLL wrapper's dynamic phase port (dynamic_en=1).
// - Takes signed phase-step requests per output channel.
// - Generates correctly timed phasesel/phasedir/phasestep sequences.
// - Tracks each channel's current phase offset modulo one period.
// - Gates all requests on a filtered PLL lock.
// - Sits between the video/DDR timing-calibration logic and the PLL instance.

---
 rtl/ecp5_pll_phase_ctrl.sv | 157 +++++++++++++++
 tb/tb_ecp5_pll_phase_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecp5_pll_phase_ctrl.sv
// Dynamic phase-step sequencer for the ECP5 PLL wrapper: filters lock, paces
// phasesel/phasedir/phasestep, and tracks per-channel phase modulo one period.
module ecp5_pll_phase_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int PHASE_W   = 10,
    parameter logic [NUM_CH*PHASE_W-1:0] CH_STEPS = {NUM_CH{PHASE_W'(40)}},
    parameter int SETUP_CYC = 2,
    parameter int STEP_W    = 2,
    parameter int STEP_GAP  = 4,
    parameter int LOCK_FILT = 16
) (
    input  logic                        clk_i,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_ch,
    input  logic signed [PHASE_W:0]     req_delta,
    input  logic                        pll_locked,
    output logic [1:0]                  pll_phasesel,
    output logic                        pll_phasedir,
    output logic                        pll_phasestep,
    output logic                        locked_o,
    output logic                        busy,
    output logic                        done,
    output logic                        err_o,
    output logic [NUM_CH*PHASE_W-1:0]   phase_o
);

    localparam int MAXC = (SETUP_CYC > STEP_W) ?
                          ((SETUP_CYC > STEP_GAP) ? SETUP_CYC : STEP_GAP) :
                          ((STEP_W > STEP_GAP) ? STEP_W : STEP_GAP);
    localparam int TW  = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int LFW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam logic [2:0] NUM_CH_L = 3'(NUM_CH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t               state_q;
    logic [TW-1:0]        tmr_q;
    logic [PHASE_W:0]     rem_q;
    logic [PHASE_W:0]     req_mag;
    logic [LFW-1:0]       lf_cnt;
    logic [PHASE_W-1:0]   phase_q [NUM_CH];

    // Unsigned magnitude: -2^PHASE_W maps to 2^PHASE_W in the extra MSB.
    assign req_mag   = req_delta[PHASE_W] ? (~req_delta + 1'b1) : req_delta;
    assign req_ready = (state_q == IDLE) && locked_o;

    always_comb begin
        phase_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            phase_o[i*PHASE_W +: PHASE_W] = phase_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            lf_cnt   <= '0;
            locked_o <= 1'b0;
        end else if (!pll_locked) begin
            lf_cnt   <= '0;
            locked_o <= 1'b0;
        end else if (lf_cnt == LFW'(LOCK_FILT - 1)) begin
            locked_o <= 1'b1;
        end else begin
            lf_cnt <= lf_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            rem_q         <= '0;
            pll_phasesel  <= '0;
            pll_phasedir  <= 1'b0;
            pll_phasestep <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_o         <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            done  <= 1'b0;
            err_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        pll_phasesel <= req_ch;
                        pll_phasedir <= req_delta[PHASE_W];
                        rem_q        <= req_mag;
                        if ({1'b0, req_ch} >= NUM_CH_L) begin
                            err_o <= 1'b1;
                        end else if (req_mag == '0) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            tmr_q   <= TW'(SETUP_CYC - 1);
                            busy    <= 1'b1;
                        end
                    end
                end
                SETUP, PULSE, GAP: begin
                    if (!pll_locked) begin
                        state_q       <= IDLE;
                        pll_phasestep <= 1'b0;
                        busy          <= 1'b0;
                        err_o         <= 1'b1;
                    end else if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
                    end else if (state_q == PULSE) begin
                        state_q       <= GAP;
                        pll_phasestep <= 1'b0;
                        tmr_q         <= TW'(STEP_GAP - 1);
                        rem_q         <= rem_q - 1'b1;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (32'(pll_phasesel) == i) begin
                                if (!pll_phasedir)
                                    phase_q[i] <= (phase_q[i] == CH_STEPS[i*PHASE_W +: PHASE_W] - PHASE_W'(1)) ?
                                                  '0 : phase_q[i] + 1'b1;
                                else
                                    phase_q[i] <= (phase_q[i] == '0) ?
                                                  CH_STEPS[i*PHASE_W +: PHASE_W] - PHASE_W'(1) : phase_q[i] - 1'b1;
                            end
                        end
                    end else if (state_q == GAP && rem_q == '0) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else begin
                        state_q       <= PULSE;
                        pll_phasestep <= 1'b1;
                        tmr_q         <= TW'(STEP_W - 1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q       <= IDLE;
                    pll_phasestep <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecp5_pll_phase_ctrl.sv
// Directed bench for ecp5_pll_phase_ctrl: a 4-channel instance plus a 3-channel
// instance sharing stimulus, so out-of-range channel handling can be exercised.
module tb_ecp5_pll_phase_ctrl;

    logic               clk_i = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready, req_ready3;
    logic [1:0]         req_ch;
    logic signed [10:0] req_delta;
    logic               pll_locked;
    logic [1:0]         pll_phasesel, pll_phasesel3;
    logic               pll_phasedir, pll_phasedir3;
    logic               pll_phasestep, pll_phasestep3;
    logic               locked_o, locked3;
    logic               busy, busy3;
    logic               done, done3;
    logic               err_o, err3;
    logic [39:0]        phase_o;
    logic [29:0]        phase3;

    int checks = 0;
    int errors = 0;

    int          step_cnt, first_step, done_at, done_cnt, err_at, err_cnt, seldir_bad;
    int          step3_cnt, done3_cnt, err3_at;
    logic [63:0] step_mask, busy_mask;

    ecp5_pll_phase_ctrl dut (
        .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_delta(req_delta), .pll_locked(pll_locked),
        .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir), .pll_phasestep(pll_phasestep),
        .locked_o(locked_o), .busy(busy), .done(done), .err_o(err_o), .phase_o(phase_o)
    );

    ecp5_pll_phase_ctrl #(.NUM_CH(3)) dut3 (
        .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
        .req_ch(req_ch), .req_delta(req_delta), .pll_locked(pll_locked),
        .pll_phasesel(pll_phasesel3), .pll_phasedir(pll_phasedir3), .pll_phasestep(pll_phasestep3),
        .locked_o(locked3), .busy(busy3), .done(done3), .err_o(err3), .phase_o(phase3)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [9:0] ph(input int ch);
        logic [39:0] v;
        v = phase_o;
        return v[ch*10 +: 10];
    endfunction

    task automatic relock();
        pll_locked = 1'b1;
        repeat (15) tick();
        check("relock_early", locked_o, 1'b0);
        tick();
        check("relock", locked_o, 1'b1);
    endtask

    // Issue one request and record per-cycle activity for cycles k+1..k+ncyc.
    task automatic run_req(input logic [1:0] ch, input int delta, input int ncyc, input int drop_at);
        check("ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        req_ch    = ch;
        req_delta = 11'(delta);
        tick();
        req_valid = 1'b0;
        req_ch    = ~ch;
        req_delta = 11'h2AA;
        step_cnt = 0; first_step = -1; done_at = -1; done_cnt = 0;
        err_at = -1; err_cnt = 0; seldir_bad = 0;
        step3_cnt = 0; done3_cnt = 0; err3_at = -1;
        step_mask = '0; busy_mask = '0;
        for (int j = 1; j <= ncyc; j++) begin
            if (pll_phasestep) begin
                step_cnt++;
                if (first_step < 0) first_step = j;
                if (j < 64) step_mask[j] = 1'b1;
            end
            if (busy && j < 64) busy_mask[j] = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (err_o) begin
                err_cnt++;
                if (err_at < 0) err_at = j;
            end
            if (busy && (pll_phasesel != ch || pll_phasedir != (delta < 0))) seldir_bad++;
            if (pll_phasestep3) step3_cnt++;
            if (done3) done3_cnt++;
            if (err3 && err3_at < 0) err3_at = j;
            if (j == drop_at) pll_locked = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_ch     = '0;
        req_delta  = '0;
        pll_locked = 1'b0;
        tick();
        tick();
        check("rst_outs", {req_ready, pll_phasesel, pll_phasedir, pll_phasestep,
                           locked_o, busy, done, err_o}, '0);
        check("rst_phase", phase_o, '0);
        check("rst_phase3", phase3, '0);

        // lock filter: 15 good, 1 bad, then 16 good
        reset      = 1'b0;
        pll_locked = 1'b1;
        repeat (15) tick();
        check("lf_15", locked_o, 1'b0);
        pll_locked = 1'b0;
        tick();
        check("lf_drop", locked_o, 1'b0);
        pll_locked = 1'b1;
        repeat (15) tick();
        check("lf_15b", locked_o, 1'b0);
        check("lf_ready0", req_ready, 1'b0);
        tick();
        check("lf_16", locked_o, 1'b1);
        check("lf_ready1", req_ready, 1'b1);

        // ch1 +3
        run_req(2'd1, 3, 24, -1);
        check("p3_stepmask", step_mask, 64'h18618);
        check("p3_busymask", busy_mask, 64'h3FFFFE);
        check("p3_done_at", done_at, 21);
        check("p3_done_cnt", done_cnt, 1);
        check("p3_err", err_cnt, 0);
        check("p3_seldir", seldir_bad, 0);
        check("p3_phase1", ph(1), 10'd3);
        check("p3_sel_hold", {pll_phasesel, pll_phasedir}, 3'b010);

        // ch2 -1 from 0 wraps to 39
        run_req(2'd2, -1, 12, -1);
        check("m1_stepmask", step_mask, 64'h18);
        check("m1_done_at", done_at, 9);
        check("m1_seldir", seldir_bad, 0);
        check("m1_dir", pll_phasedir, 1'b1);
        check("m1_phase2", ph(2), 10'd39);
        check("m1_phase2_3", phase3[20 +: 10], 10'd39);

        // ch2 +40 full turn
        run_req(2'd2, 40, 250, -1);
        check("p40_steps", step_cnt, 80);
        check("p40_first", first_step, 3);
        check("p40_done_at", done_at, 243);
        check("p40_phase2", ph(2), 10'd39);
        check("p40_phase1", ph(1), 10'd3);

        // ch0 zero delta
        run_req(2'd0, 0, 4, -1);
        check("z_steps", step_cnt, 0);
        check("z_done_at", done_at, 1);
        check("z_done_cnt", done_cnt, 1);
        check("z_busymask", busy_mask, 64'h2);
        check("z_phase0", ph(0), 10'd0);

        // ch3: valid on 4-ch instance, out of range on 3-ch instance
        run_req(2'd3, 0, 4, -1);
        check("ch3_done_at", done_at, 1);
        check("bad_err_at", err3_at, 1);
        check("bad_done", done3_cnt, 0);
        check("bad_steps", step3_cnt, 0);

        // most negative delta: 1024 lead steps, 1024 mod 40 = 24 -> 16
        run_req(2'd3, -1024, 6150, -1);
        check("min_steps", step_cnt, 2048);
        check("min_done_at", done_at, 6147);
        check("min_phase3", ph(3), 10'd16);
        check("min_bad_steps", step3_cnt, 0);

        // lock loss during third pulse of a +5 on ch0
        run_req(2'd0, 5, 20, 15);
        check("ll_stepmask", step_mask, 64'h8618);
        check("ll_err_at", err_at, 16);
        check("ll_err_cnt", err_cnt, 1);
        check("ll_done", done_cnt, 0);
        check("ll_phase0", ph(0), 10'd2);
        check("ll_ready", req_ready, 1'b0);
        relock();
        check("ll_ready_back", req_ready, 1'b1);

        // async reset during GAP of a +4 on ch1
        run_req(2'd1, 4, 6, -1);
        check("rg_phase1", ph(1), 10'd4);
        check("rg_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rg_outs", {req_ready, pll_phasesel, pll_phasedir, pll_phasestep,
                          locked_o, busy, done, err_o}, '0);
        check("rg_phase", phase_o, '0);
        tick();
        tick();
        reset = 1'b0;
        relock();
        run_req(2'd1, 2, 16, -1);
        check("post_done_at", done_at, 15);
        check("post_stepmask", step_mask, 64'h618);
        check("post_phase1", ph(1), 10'd2);
        check("post_phase2", ph(2), 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
